phase_ctrl: RTL

Multi-cycle phase sequencer that drives the register file and memory port of the CPU core. It advances a one-hot `phase` vector through fetch, read, execute, memory and final (writeback). It holds the program counter and instruction register, and extracts the register-file selects `rg1`/`rg2`. It is the driving end of the register-file interface: the register file only samples `phase`, `rg1` and `rg2`; this block decides when each phase occurs and for how long.

---
 rtl/phase_ctrl_pkg.sv | 27 ++
 rtl/phase_ctrl_op_class.sv | 19 +
 rtl/phase_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/phase_ctrl_pkg.sv
// Shared constants for the phase sequencer and the register file: phase bit
// indices, the one-hot phase encoding and the opcode values.
package phase_ctrl_pkg;

    localparam int PHASE_H  = 4;
    localparam int PH_I_BIT = 0;
    localparam int PH_R_BIT = 1;
    localparam int PH_E_BIT = 2;
    localparam int PH_M_BIT = 3;
    localparam int PH_F_BIT = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    // The state register is the one-hot phase vector; all-zero means halted.
    typedef enum logic [PHASE_H:0] {
        PH_HALT = '0,
        PH_I    = (PHASE_H+1)'(1) << PH_I_BIT,
        PH_R    = (PHASE_H+1)'(1) << PH_R_BIT,
        PH_E    = (PHASE_H+1)'(1) << PH_E_BIT,
        PH_M    = (PHASE_H+1)'(1) << PH_M_BIT,
        PH_F    = (PHASE_H+1)'(1) << PH_F_BIT
    } phase_e;

endpackage

// File: rtl/phase_ctrl_op_class.sv
// Combinational opcode classifier: tells the sequencer which phases an
// instruction needs after execute.
module op_class
    import phase_ctrl_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       is_mem_o,
    output logic       is_st_o,
    output logic       wb_en_o,
    output logic       is_halt_o
);

    assign is_mem_o  = (opcode_i == OP_LD) || (opcode_i == OP_ST);
    assign is_st_o   = (opcode_i == OP_ST);
    assign is_halt_o = (opcode_i == OP_HLT);
    // Everything except NOP, ST and HLT writes back (LD and all ALU codes).
    assign wb_en_o   = !((opcode_i == OP_NOP) || (opcode_i == OP_ST) || (opcode_i == OP_HLT));

endmodule

// File: rtl/phase_ctrl.sv
// Multi-cycle phase sequencer: fetch/read/execute/memory/final, holding PC and
// IR and driving the memory port and the register-file selects.
module phase_ctrl
    import phase_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic [31:0]       addr_in,
    output logic [PHASE_H:0]  phase,
    output logic [31:0]       ir,
    output logic [2:0]        rg1,
    output logic [2:0]        rg2,
    output logic [31:0]       pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic              halted
);

    phase_e      phase_q, phase_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        halted_q, halted_d;

    logic is_mem, is_st, wb_en, is_halt;

    op_class u_op_class (
        .opcode_i  (ir_q[31:28]),
        .is_mem_o  (is_mem),
        .is_st_o   (is_st),
        .wb_en_o   (wb_en),
        .is_halt_o (is_halt)
    );

    always_comb begin
        phase_d  = phase_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        case (phase_q)
            PH_I: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    phase_d = PH_R;
                end
            end
            PH_R: phase_d = PH_E;
            PH_E: begin
                if (is_halt) begin
                    phase_d  = PH_HALT;
                    halted_d = 1'b1;
                end else if (is_mem) begin
                    phase_d = PH_M;
                end else if (wb_en) begin
                    phase_d = PH_F;
                end else begin
                    phase_d = PH_I;
                end
            end
            PH_M: begin
                if (mem_ack) phase_d = wb_en ? PH_F : PH_I;
            end
            PH_F:    phase_d = PH_I;
            PH_HALT: phase_d = PH_HALT;
            default: phase_d = PH_I;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_I;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    assign phase    = phase_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign halted   = halted_q;
    assign rg1      = ir_q[27:25];
    assign rg2      = ir_q[24:22];
    assign mem_req  = (phase_q == PH_I) || (phase_q == PH_M);
    assign mem_we   = (phase_q == PH_M) && is_st;
    assign mem_addr = (phase_q == PH_I) ? pc_q :
                      (phase_q == PH_M) ? addr_in : 32'h0;

endmodule
